pixel_uart_tx: RTL and testbench

Serializes 24-bit RGB pixels onto a UART line as three 8N1 byte frames. Red goes first, then green, then blue. This is the transmit end of the serial pixel link that feeds the VGA serial display path. Pixel packing is the same as the display datapath: [7:0] red, [15:8] green, [23:16] blue. Upstream logic presents pixels with a valid/ready handshake; the block owns the tx pin.

---
 rtl/pixel_uart_tx.sv | 121 ++++++++++++
 tb/tb_pixel_uart_tx.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_uart_tx.sv
// Serializes 24-bit RGB pixels as three back-to-back 8N1 UART frames (red, green, blue).
// Pixels enter through a valid/ready handshake and are shadowed for the whole frame.
module pixel_uart_tx #(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUD_RATE = 115200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] pixel_in,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        tx,
  output logic        busy,
  output logic        pixel_sent
);

  localparam int BAUD_DIV = CLK_FREQ / BAUD_RATE;
  localparam int CW = (BAUD_DIV < 2) ? 1 : $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  if (BAUD_DIV < 2) begin : g_bad_baud_div
    $error("pixel_uart_tx: CLK_FREQ/BAUD_RATE must be at least 2");
  end

  // Handshake: a pixel transfers on a rising edge where pixel_valid && pixel_ready.
  // pixel_ready is high only in IDLE; pixel_valid/pixel_in are ignored elsewhere.
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [1:0]    byte_idx;
  logic [23:0]   shadow;
  logic [7:0]    cur_byte;
  logic          baud_done;

  always_comb begin
    cur_byte = shadow[23:16];
    case (byte_idx)
      2'd0:    cur_byte = shadow[7:0];
      2'd1:    cur_byte = shadow[15:8];
      default: cur_byte = shadow[23:16];
    endcase
  end

  assign baud_done   = (baud_cnt == BAUD_LAST);
  assign pixel_ready = (state == IDLE);
  assign busy        = (state != IDLE);

  // tx is loaded one bit ahead so the line changes on the same edge as the state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tx         <= 1'b1;
      pixel_sent <= 1'b0;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      byte_idx   <= '0;
      shadow     <= '0;
    end else begin
      pixel_sent <= 1'b0;
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          if (pixel_valid) begin
            shadow   <= pixel_in;
            byte_idx <= 2'd0;
            tx       <= 1'b0;
            state    <= START;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            tx       <= cur_byte[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_byte[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (byte_idx == 2'd2) begin
              pixel_sent <= 1'b1;
              state      <= IDLE;
            end else begin
              // Next byte starts immediately: no idle gap inside a pixel.
              byte_idx <= byte_idx + 2'd1;
              tx       <= 1'b0;
              state    <= START;
            end
          end else begin
            baud_cnt <= baud_cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pixel_uart_tx.sv
// Bench for pixel_uart_tx at BAUD_DIV=4: a line monitor decodes frames against an
// expected-byte queue, while table vectors and hand sequences check handshake timing.
module tb_pixel_uart_tx;

  logic        clk;
  logic        rst;
  logic [23:0] pixel_in;
  logic        pixel_valid;
  logic        pixel_ready;
  logic        tx;
  logic        busy;
  logic        pixel_sent;

  int n_vec = 0;
  int n_bad = 0;
  logic [7:0] exp_q[$];

  pixel_uart_tx #(.CLK_FREQ(40), .BAUD_RATE(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pixel_ready (pixel_ready),
    .tx          (tx),
    .busy        (busy),
    .pixel_sent  (pixel_sent)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int actual, input int expected);
    n_vec++;
    if (actual !== expected) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, actual, actual, expected, expected);
    end
  endtask

  // ---------------- line monitor / scoreboard ----------------
  // Samples mid-bit on falling edges; a reset inside a frame abandons it.
  initial begin
    logic [9:0] fr;
    logic       aborted;
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (!rst && tx === 1'b0) begin
        aborted = 1'b0;
        fr      = '0;
        for (int b = 0; b < 10; b++) begin
          for (int c = 0; c < ((b == 0) ? 2 : 4); c++) begin
            @(negedge clk);
            if (rst) aborted = 1'b1;
          end
          if (aborted) break;
          fr[b] = tx;
        end
        if (!aborted) begin
          if (exp_q.size() == 0) begin
            chk("unexpected_frame", int'(fr), 0);
          end else begin
            e = exp_q.pop_front();
            chk("frame_bits", int'(fr), int'({1'b1, e, 1'b0}));
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic offer(input logic [23:0] px);
    int n;
    n = 0;
    while (!pixel_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_offer", int'(pixel_ready), 1);
    pixel_in    = px;
    pixel_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    pixel_valid = 1'b0;
  endtask

  // Called on the first falling edge after acceptance (k=1).
  task automatic track(input int poke_k, input logic [23:0] poke_px, input logic poke_v);
    int k;
    int sent_at;
    int hold_err;
    k = 1;
    sent_at = 0;
    hold_err = 0;
    while (k <= 200) begin
      if (k == poke_k) begin
        pixel_in    = poke_px;
        pixel_valid = poke_v;
      end else if (k == poke_k + 1) begin
        pixel_valid = 1'b0;
      end
      if (pixel_sent) begin
        sent_at = k;
        break;
      end
      if (pixel_ready || !busy) hold_err++;
      @(negedge clk);
      k++;
    end
    chk("sent_latency", sent_at, 121);
    chk("ready_low_in_frame", hold_err, 0);
    chk("ready_at_sent", int'(pixel_ready), 1);
    chk("busy_at_sent", int'(busy), 0);
    @(negedge clk);
    chk("sent_pulse_width", int'(pixel_sent), 0);
  endtask

  typedef struct {
    logic [23:0] pixel;
    logic [7:0]  r;
    logic [7:0]  g;
    logic [7:0]  b;
  } vec_t;

  vec_t tab[4];

  // ---------------- test sequence ----------------
  initial begin
    int k1;
    int k2;
    int pulses;
    int errs;
    logic tx_gap;
    logic tx_next;
    logic rdy_gap;
    logic rdy_next;

    tab[0] = '{24'hA53C0F, 8'h0F, 8'h3C, 8'hA5};
    tab[1] = '{24'h000000, 8'h00, 8'h00, 8'h00};
    tab[2] = '{24'hFFFFFF, 8'hFF, 8'hFF, 8'hFF};
    tab[3] = '{24'h5A81C3, 8'hC3, 8'h81, 8'h5A};

    rst         = 1'b1;
    pixel_in    = '0;
    pixel_valid = 1'b0;

    // Reset idle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst_tx", int'(tx), 1);
      chk("rst_ready", int'(pixel_ready), 1);
      chk("rst_busy", int'(busy), 0);
      chk("rst_sent", int'(pixel_sent), 0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Single pixels from the table
    for (int i = 0; i < 4; i++) begin
      offer(tab[i].pixel);
      exp_q.push_back(tab[i].r);
      exp_q.push_back(tab[i].g);
      exp_q.push_back(tab[i].b);
      track(0, 24'h0, 1'b0);
      repeat (3) @(negedge clk);
    end

    // Back-to-back with valid held high
    pixel_in    = 24'h000000;
    pixel_valid = 1'b1;
    repeat (3) exp_q.push_back(8'h00);
    repeat (3) exp_q.push_back(8'hFF);
    @(posedge clk);
    @(negedge clk);
    pixel_in = 24'hFFFFFF;
    k1 = 0; k2 = 0; pulses = 0;
    tx_gap = 1'b0; tx_next = 1'b1; rdy_gap = 1'b0; rdy_next = 1'b1;
    for (int k = 1; k <= 260; k++) begin
      if (pixel_sent) begin
        pulses++;
        if (k1 == 0) k1 = k; else if (k2 == 0) k2 = k;
      end
      if (k1 != 0 && k == k1) begin
        tx_gap  = tx;
        rdy_gap = pixel_ready;
      end
      if (k1 != 0 && k == k1 + 1) begin
        tx_next     = tx;
        rdy_next    = pixel_ready;
        pixel_valid = 1'b0;
      end
      @(negedge clk);
    end
    chk("b2b_first_sent", k1, 121);
    chk("b2b_second_sent", k2, 242);
    chk("b2b_pulses", pulses, 2);
    chk("b2b_gap_tx_high", int'(tx_gap), 1);
    chk("b2b_gap_ready", int'(rdy_gap), 1);
    chk("b2b_next_start_low", int'(tx_next), 0);
    chk("b2b_next_ready_low", int'(rdy_next), 0);
    pixel_valid = 1'b0;
    repeat (3) @(negedge clk);

    // Input stability: pixel_in changes during the green byte
    offer(24'hA53C0F);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hA5);
    track(50, 24'h123456, 1'b0);
    errs = 0;
    repeat (20) begin
      @(negedge clk);
      if (tx !== 1'b1 || busy !== 1'b0) errs++;
    end
    chk("stable_no_resend", errs, 0);

    // Valid pulsed while a frame is in flight
    offer(24'h0102FE);
    exp_q.push_back(8'hFE);
    exp_q.push_back(8'h02);
    exp_q.push_back(8'h01);
    track(60, 24'h777777, 1'b1);
    errs = 0;
    repeat (40) begin
      @(negedge clk);
      if (tx !== 1'b1 || pixel_sent !== 1'b0 || pixel_ready !== 1'b1) errs++;
    end
    chk("busy_valid_ignored", errs, 0);

    // Reset during a green data bit (tx low there)
    offer(24'hA53C0F);
    exp_q.push_back(8'h0F);
    exp_q.push_back(8'h3C);
    exp_q.push_back(8'hA5);
    repeat (45) @(negedge clk);
    chk("pre_rst_tx_low", int'(tx), 0);
    rst = 1'b1;
    #1;
    chk("async_rst_tx", int'(tx), 1);
    chk("async_rst_busy", int'(busy), 0);
    chk("async_rst_ready", int'(pixel_ready), 1);
    exp_q.delete();
    pulses = 0;
    repeat (3) begin
      @(negedge clk);
      if (pixel_sent) pulses++;
    end
    rst = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (pixel_sent) pulses++;
    end
    chk("rst_no_sent", pulses, 0);
    offer(24'h0000AA);
    exp_q.push_back(8'hAA);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'h00);
    track(0, 24'h0, 1'b0);

    repeat (10) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
